mul_dot_accumulator: RTL and testbench
======================================

// Module: mul_dot_accumulator
//
// PURPOSE
//   Downstream consumer of the signed/unsigned N-bit multiplier's 2N-bit product.
//   Accumulates `len` consecutive products into one dot-product result.
//   Extends each product per the signedness flag latched with the first term.
//   Sits between the multiplier and the result writeback; valid/ready on both sides.
//
// PARAMETERS
//   n      8                     operand width; product width is 2*n
//   len    4                     products per dot product; legal range >= 1
//   out_w  2*n + $clog2(len)     result width; the default can never overflow
//   localparam acc_w = 2*n + $clog2(len) + 1   internal accumulator width
//
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   prod_vld     in   1      product present on prod
//   prod_rdy     out  1      block accepts prod this cycle
//   prod         in   2*n    raw product bits from the multiplier
//   prod_signed  in   1      1 = prod is two's complement, 0 = unsigned
//   sum_vld      out  1      dot-product result valid
//   sum_rdy      in   1      downstream accepts result
//   sum          out  out_w  accumulated result
//   sum_signed   out  1      signedness of sum (the latched mode)
//   ovf          out  1      saturation occurred; exists only with the macro
//
// BEHAVIOUR
//   - Transfer rules
//     - Input transfer = prod_vld & prod_rdy.
//     - Output transfer = sum_vld & sum_rdy.
//   - Reset (async assert, sync release)
//     - state=IDLE; acc, cnt, sum, sum_signed, ovf all 0; sum_vld=0.
//   - FSM states: IDLE, ACC, OUT
//     - IDLE: prod_rdy=1.
//       - On input transfer: acc <= ext(prod), cnt <= 1, mode <= prod_signed.
//       - Go to OUT if len==1, else ACC.
//     - ACC: prod_rdy=1.
//       - On input transfer: acc <= acc + ext(prod), cnt++.
//       - The term that makes cnt==len moves the FSM to OUT.
//       - prod_signed of terms 2..len is ignored; the mode latched at term 1 governs.
//     - OUT: sum_vld=1, sum/sum_signed held stable; prod_rdy = sum_rdy (combinational).
//       - Output transfer with no input transfer -> IDLE.
//       - Output and input transfer in the same cycle -> start a new vector
//         (IDLE load rules), no bubble.
//   - Registering and latency
//     - sum and sum_signed are registered, loaded on entry to OUT.
//     - Latency: last input transfer -> sum_vld high on the next cycle.
//   - Extension ext(prod)
//     - mode=1: sign-extend prod to acc_w.
//     - mode=0: zero-extend prod to acc_w.
//     - All adds are done in acc_w bits.
//   - sum vs out_w
//     - out_w >= needed width: sum = acc[out_w-1:0].
//     - Otherwise see CONFIGURATION.
//   - Reset mid-vector discards the partial acc; the next vector starts clean.
//   - prod_vld while sum_vld=1 and sum_rdy=0: stall; prod_rdy=0, no state change.
//
// CONFIGURATION
//   MUL_DOT_ACC_SAT_EN defined:
//     - sum = acc saturated to the out_w range for the mode.
//       - unsigned: [0, 2^out_w - 1]
//       - signed:   [-2^(out_w-1), 2^(out_w-1) - 1]
//     - ovf = 1 with that sum when clamping occurred; registered alongside sum.
//   MUL_DOT_ACC_SAT_EN undefined:
//     - sum = acc[out_w-1:0], i.e. wrap-around.
//     - The ovf port is not present.
//
// STRUCTURE
//   - Package mul_dot_acc_pkg holds:
//     - enum logic [1:0] state_t {IDLE, ACC, OUT}
//     - function clog2_len helper
//   - Sub-module mul_dot_sat: combinational clamp of acc_w to out_w by mode, with ovf.
//     Instantiated only under MUL_DOT_ACC_SAT_EN.
//
// TESTING (n=8, len=4 unless noted)
//   1. Unsigned: 4 x prod=16'hFE01 (255*255), prod_signed=0
//      -> sum=260100 (0x3F804), sum_signed=0, 1 cycle after the 4th transfer.
//   2. Signed: 16'h4000, 16'hC080, 16'hC080, 16'h4000 with prod_signed=1 -> sum=256.
//      Same bits with prod_signed=0 -> sum=131328.
//   3. Backpressure: hold sum_rdy=0 for 5 cycles
//      -> sum stable, prod_rdy=0.
//      Then sum_rdy=1 with prod_vld=1 -> result drained and the new term accepted
//      in the same cycle.
//   4. Reset: assert rst_n=0 after 2 terms of a vector
//      -> all outputs 0 immediately.
//      Next vector of 4 x 16'h0001 -> sum=4.
//   5. len=1: each single product 16'h0064 -> sum=100 with 1-cycle latency.
//      Back-to-back with sum_rdy=1 -> one result per cycle.
//   6. Saturation, macro on, out_w=16:
//      - unsigned 4 x 16'hFE01 -> sum=16'hFFFF, ovf=1.
//      - signed 4 x 16'hC080   -> sum=16'h8000, ovf=1.
//      Macro off: unsigned case -> sum=16'hF804.

Source files
------------

// File: rtl/mul_dot_acc_pkg.sv
// Shared types and helpers for the dot-product accumulator.
package mul_dot_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Ceiling log2; clog2_len(1) == 0.
  function automatic int unsigned clog2_len(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < {32'd0, v}) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_dot_accumulator_if.sv
// Product-in / sum-out handshake bundle for mul_dot_accumulator.
interface mul_dot_accumulator_if #(
  parameter int unsigned n     = 8,
  parameter int unsigned out_w = 18
);
  logic             prod_vld;
  logic             prod_rdy;
  logic [2*n-1:0]   prod;
  logic             prod_signed;
  logic             sum_vld;
  logic             sum_rdy;
  logic [out_w-1:0] sum;
  logic             sum_signed;

  modport master (
    output prod_vld, prod, prod_signed, sum_rdy,
    input  prod_rdy, sum_vld, sum, sum_signed
  );

  modport slave (
    input  prod_vld, prod, prod_signed, sum_rdy,
    output prod_rdy, sum_vld, sum, sum_signed
  );
endinterface

// File: rtl/mul_dot_sat.sv
// Combinational clamp of an acc_w-bit accumulator to out_w bits,
// unsigned or two's complement range selected by mode.
module mul_dot_sat #(
  parameter int unsigned acc_w = 19,
  parameter int unsigned out_w = 18
) (
  input  logic [acc_w-1:0] acc,
  input  logic             mode,
  output logic [out_w-1:0] sum,
  output logic             ovf
);

  generate
    if (out_w >= acc_w) begin : g_fits
      always_comb begin
        sum = mode ? out_w'($signed(acc)) : out_w'(acc);
        ovf = 1'b0;
      end
    end else begin : g_clamp
      logic [acc_w-out_w-1:0] hi_u;
      logic [acc_w-out_w:0]   hi_s;
      logic                   neg;
      logic                   ovf_u;
      logic                   ovf_s;
      logic [out_w-1:0]       smax;

      assign hi_u  = acc[acc_w-1:out_w];
      assign hi_s  = acc[acc_w-1:out_w-1];
      assign neg   = acc[acc_w-1];
      assign ovf_u = |hi_u;
      // Signed value fits only when the bits above the new sign bit all copy it.
      assign ovf_s = ~((&hi_s) | ~(|hi_s));

      always_comb begin
        smax = '1;
        smax[out_w-1] = 1'b0;
        sum = acc[out_w-1:0];
        ovf = 1'b0;
        if (mode) begin
          if (ovf_s) begin
            sum = neg ? ~smax : smax;
            ovf = 1'b1;
          end
        end else if (ovf_u) begin
          sum = neg ? '0 : '1;
          ovf = 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mul_dot_accumulator.sv
// Accumulates len consecutive multiplier products into one registered sum.
// Define MUL_DOT_ACC_SAT_EN to saturate the sum to out_w and expose ovf.
module mul_dot_accumulator
  import mul_dot_acc_pkg::*;
#(
  parameter int unsigned n     = 8,
  parameter int unsigned len   = 4,
  parameter int unsigned out_w = 2*n + clog2_len(len)
) (
  input  logic clk,
  input  logic rst_n,
  mul_dot_accumulator_if.slave bus
`ifdef MUL_DOT_ACC_SAT_EN
  ,
  output logic ovf
`endif
);

  localparam int unsigned acc_w = 2*n + clog2_len(len) + 1;
  localparam int unsigned cnt_w = clog2_len(len + 1);
  localparam logic [cnt_w-1:0] len_c = cnt_w'(len);

  state_t           state, state_nxt;
  logic [acc_w-1:0] acc, acc_nxt, term;
  logic [cnt_w-1:0] cnt, cnt_nxt;
  logic             mode, mode_nxt;
  logic [out_w-1:0] sum_q, sum_d;
  logic             sum_signed_q;
  logic             ovf_q, ovf_d;
  logic             prod_rdy, sum_vld;
  logic             in_xfer, first, done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    prod_rdy  = 1'b0;
    sum_vld   = 1'b0;
    case (state)
      IDLE: prod_rdy = 1'b1;
      ACC:  prod_rdy = 1'b1;
      OUT: begin
        sum_vld  = 1'b1;
        prod_rdy = bus.sum_rdy;
      end
      default: prod_rdy = 1'b0;
    endcase

    in_xfer  = bus.prod_vld & prod_rdy;
    // A transfer outside ACC always opens a new vector (from IDLE or OUT).
    first    = in_xfer & (state != ACC);
    mode_nxt = first ? bus.prod_signed : mode;
    term     = mode_nxt ? acc_w'($signed(bus.prod)) : acc_w'(bus.prod);
    acc_nxt  = first ? term : acc + term;
    cnt_nxt  = first ? cnt_w'(1) : cnt + cnt_w'(1);
    done     = in_xfer & (cnt_nxt == len_c);

    case (state)
      IDLE: if (in_xfer) state_nxt = done ? OUT : ACC;
      ACC:  if (done)    state_nxt = OUT;
      OUT: begin
        if (in_xfer)          state_nxt = done ? OUT : ACC;
        else if (bus.sum_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MUL_DOT_ACC_SAT_EN
  mul_dot_sat #(
    .acc_w (acc_w),
    .out_w (out_w)
  ) u_sat (
    .acc  (acc_nxt),
    .mode (mode_nxt),
    .sum  (sum_d),
    .ovf  (ovf_d)
  );
`else
  localparam int unsigned ext_w = (out_w > acc_w) ? out_w : acc_w;
  always_comb begin
    sum_d = out_w'(mode_nxt ? ext_w'($signed(acc_nxt)) : ext_w'(acc_nxt));
    ovf_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      mode         <= 1'b0;
      sum_q        <= '0;
      sum_signed_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      if (in_xfer) begin
        acc  <= acc_nxt;
        cnt  <= cnt_nxt;
        mode <= mode_nxt;
      end
      if (done) begin
        sum_q        <= sum_d;
        sum_signed_q <= mode_nxt;
        ovf_q        <= ovf_d;
      end
    end
  end

  assign bus.prod_rdy   = prod_rdy;
  assign bus.sum_vld    = sum_vld;
  assign bus.sum        = sum_q;
  assign bus.sum_signed = sum_signed_q;

`ifdef MUL_DOT_ACC_SAT_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mul_dot_accumulator.sv
// Self-checking bench: vector table, hand sequences and random vectors
// against an arithmetic reference model, on len=4, len=1 and out_w=16 instances.
module tb_mul_dot_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  mul_dot_accumulator_if #(.n(8), .out_w(18)) m  ();
  mul_dot_accumulator_if #(.n(8), .out_w(16)) s1 ();
  mul_dot_accumulator_if #(.n(8), .out_w(16)) w  ();

`ifdef MUL_DOT_ACC_SAT_EN
  logic ovf_m, ovf_s1, ovf_w;
`endif

  mul_dot_accumulator #(.n(8), .len(4)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(m)
`ifdef MUL_DOT_ACC_SAT_EN
    , .ovf(ovf_m)
`endif
  );

  mul_dot_accumulator #(.n(8), .len(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .bus(s1)
`ifdef MUL_DOT_ACC_SAT_EN
    , .ovf(ovf_s1)
`endif
  );

  mul_dot_accumulator #(.n(8), .len(4), .out_w(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(w)
`ifdef MUL_DOT_ACC_SAT_EN
    , .ovf(ovf_w)
`endif
  );

  typedef struct {
    logic [3:0][15:0] p;
    logic [3:0]       sg;
    logic [17:0]      sum;
    logic             ss;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one term on the len=4 instance and wait (bounded) for its transfer.
  task automatic m_term(input logic [15:0] p, input logic sg);
    m.prod_vld = 1'b1;
    m.prod = p;
    m.prod_signed = sg;
    #1;
    for (int i = 0; i < 50 && !m.prod_rdy; i++) tick();
    if (!m.prod_rdy) chk("m_rdy_timeout", 0, 1);
    tick();
    m.prod_vld = 1'b0;
  endtask

  task automatic run_vec(input logic [3:0][15:0] p, input logic [3:0] sg,
                         input logic [17:0] es, input logic ess,
                         input int stall, input int gap, input string nm);
    m.sum_rdy = (stall == 0);
    for (int k = 0; k < 4; k++) begin
      if (gap > 0) repeat ($urandom_range(gap)) tick();
      m_term(p[k], sg[k]);
    end
    chk({nm, "_vld"}, m.sum_vld, 1);
    chk({nm, "_sum"}, m.sum, es);
    chk({nm, "_ss"}, m.sum_signed, ess);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({nm, "_hold"}, {m.sum_vld, m.sum}, {1'b1, es});
    end
    m.sum_rdy = 1'b1;
    tick();
    chk({nm, "_drain"}, m.sum_vld, 0);
  endtask

  // Reference: mode from term 1, plain integer sum, kept modulo 2^18.
  function automatic logic [17:0] model(input logic [3:0][15:0] p, input logic [3:0] sg);
    longint t = 0;
    for (int k = 0; k < 4; k++)
      t += sg[0] ? longint'($signed(p[k])) : longint'(p[k]);
    return t[17:0];
  endfunction

  vec_t tbl[7];
  logic [15:0] s1_p[4];
  logic        s1_sg[4];
  logic [15:0] s1_e[4];

  initial begin
    m.prod_vld = 0;  m.prod = '0;  m.prod_signed = 0;  m.sum_rdy = 1;
    s1.prod_vld = 0; s1.prod = '0; s1.prod_signed = 0; s1.sum_rdy = 1;
    w.prod_vld = 0;  w.prod = '0;  w.prod_signed = 0;  w.sum_rdy = 1;

    tbl[0] = '{p: {4{16'hFE01}}, sg: 4'b0000, sum: 18'h3F804, ss: 1'b0};
    tbl[1] = '{p: {16'h4000, 16'hC080, 16'hC080, 16'h4000}, sg: 4'b1111, sum: 18'd256, ss: 1'b1};
    tbl[2] = '{p: {16'h4000, 16'hC080, 16'hC080, 16'h4000}, sg: 4'b0000, sum: 18'd131328, ss: 1'b0};
    tbl[3] = '{p: {4{16'h8000}}, sg: 4'b1111, sum: 18'h20000, ss: 1'b1};
    tbl[4] = '{p: {16'h0001, 16'h0001, 16'h0001, 16'hFFFF}, sg: 4'b1110, sum: 18'h10002, ss: 1'b0};
    tbl[5] = '{p: {16'h0001, 16'h0001, 16'h0001, 16'hFFFF}, sg: 4'b0001, sum: 18'd2, ss: 1'b1};
    tbl[6] = '{p: {4{16'h0000}}, sg: 4'b0000, sum: 18'd0, ss: 1'b0};

    repeat (2) tick();
    chk("rst_vld", m.sum_vld, 0);
    chk("rst_sum", m.sum, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_rdy", m.prod_rdy, 1);
    chk("idle_vld", m.sum_vld, 0);

    for (int v = 0; v < 7; v++)
      run_vec(tbl[v].p, tbl[v].sg, tbl[v].sum, tbl[v].ss, 0, 0, $sformatf("tbl%0d", v));

    // Backpressure: result held while a new first term waits, then both move together.
    m.sum_rdy = 1'b0;
    for (int k = 0; k < 4; k++) m_term(16'h0100, 1'b0);
    m.prod_vld = 1'b1; m.prod = 16'h0002; m.prod_signed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rdy", m.prod_rdy, 0);
      chk("bp_sum", {m.sum_vld, m.sum}, {1'b1, 18'd1024});
      tick();
    end
    m.sum_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", m.prod_rdy, 1);
    tick();
    m.prod_vld = 1'b0;
    chk("bp_new_term", m.sum_vld, 0);
    for (int k = 0; k < 3; k++) m_term(16'h0002, 1'b0);
    chk("bp_next_sum", {m.sum_vld, m.sum}, {1'b1, 18'd8});
    tick();

    // Reset mid-vector discards the partial sum.
    m_term(16'h0005, 1'b1);
    m_term(16'h0005, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", m.sum_vld, 0);
    chk("midrst_sum", m.sum, 0);
    chk("midrst_ss", m.sum_signed, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_vec({4{16'h0001}}, 4'b0000, 18'd4, 1'b0, 0, 0, "after_rst");

    for (int r = 0; r < 40; r++) begin
      logic [3:0][15:0] rp;
      logic [3:0]       rs;
      for (int k = 0; k < 4; k++) rp[k] = 16'($urandom);
      rs = 4'($urandom);
      run_vec(rp, rs, model(rp, rs), rs[0], $urandom_range(3), 2, $sformatf("rnd%0d", r));
    end

    // len=1: one result per cycle when back-to-back.
    s1_p  = '{16'h0064, 16'h00C8, 16'hFF9C, 16'h0064};
    s1_sg = '{1'b0, 1'b0, 1'b1, 1'b0};
    s1_e  = '{16'd100, 16'd200, 16'hFF9C, 16'd100};
    for (int k = 0; k < 4; k++) begin
      s1.prod_vld = 1'b1; s1.prod = s1_p[k]; s1.prod_signed = s1_sg[k];
      #1;
      chk($sformatf("len1_rdy%0d", k), s1.prod_rdy, 1);
      tick();
      chk($sformatf("len1_sum%0d", k), {s1.sum_vld, s1.sum_signed, s1.sum}, {1'b1, s1_sg[k], s1_e[k]});
    end
    s1.prod_vld = 1'b0;
    tick();
    chk("len1_drain", s1.sum_vld, 0);

    // out_w=16: wrap by default, clamp when saturation is built in.
    w.prod_vld = 1'b1; w.prod = 16'hFE01; w.prod_signed = 1'b0;
    repeat (4) tick();
    w.prod_vld = 1'b0;
    chk("w16_u_vld", w.sum_vld, 1);
`ifdef MUL_DOT_ACC_SAT_EN
    chk("w16_u_sum", w.sum, 16'hFFFF);
    chk("w16_u_ovf", ovf_w, 1);
`else
    chk("w16_u_sum", w.sum, 16'hF804);
`endif
    tick();
    w.prod_vld = 1'b1; w.prod = 16'hC080; w.prod_signed = 1'b1;
    repeat (4) tick();
    w.prod_vld = 1'b0;
    chk("w16_s_ss", {w.sum_vld, w.sum_signed}, 2'b11);
`ifdef MUL_DOT_ACC_SAT_EN
    chk("w16_s_sum", w.sum, 16'h8000);
    chk("w16_s_ovf", ovf_w, 1);
`else
    chk("w16_s_sum", w.sum, 16'h0200);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
